// File: rtl/trig_coinc_capture.sv
`default_nettype none
//==============================================================================
// Module   : trig_coinc_capture
// Desc     : Coincidence-window trigger front end with multiplicity threshold,
//            external trigger and first-word-fall-through event FIFO.
//            Optional macro TRIG_TIMESTAMP_EN adds a 32-bit event timestamp (evt_ts).
// Revision : 1.0 - initial release
//==============================================================================
module trig_coinc_capture #(
    parameter int N_CH       = 24,
    parameter int WINDOW     = 24,
    parameter int TRIG_LEN   = 3,
    parameter int HOLDOFF    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int MW         = $clog2(N_CH + 1)
) (
    input  logic            pll_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] c_input,
    input  logic [N_CH-1:0] chan_mask,
    input  logic            trig_in,
    input  logic [MW-1:0]   min_mult,
    output logic            trig_out,
    output logic            veto_out,
    output logic [N_CH-1:0] evt_pattern,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [7:0]      drop_count
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [31:0]     evt_ts
`endif
);

    localparam int c_ww = $clog2(WINDOW + 1);
    localparam int c_tw = $clog2(TRIG_LEN + 1);
    localparam int c_hw = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int c_pw = $clog2(FIFO_DEPTH);
`ifdef TRIG_TIMESTAMP_EN
    localparam int c_ew = N_CH + 32;
`else
    localparam int c_ew = N_CH;
`endif

    localparam logic [c_ww-1:0] c_wlast = c_ww'(WINDOW);
    localparam logic [c_tw-1:0] c_tlast = c_tw'(TRIG_LEN);
    localparam logic [c_hw-1:0] c_hlast = c_hw'(HOLDOFF);
    localparam logic [c_pw:0]   c_depth = (c_pw + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_FIRE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    logic [N_CH-1:0]   r_c_s1, r_c_s2, r_c_s3;
    logic              r_t_s1, r_t_s2, r_t_s3;
    logic [N_CH-1:0]   r_commit;
    logic [c_ww-1:0]   r_wcnt;
    logic [c_tw-1:0]   r_tcnt;
    logic [c_hw-1:0]   r_hcnt;
    logic              r_trig;
    logic              r_veto;

    logic [N_CH-1:0]   w_hit;
    logic              w_trg_edge;
    logic [N_CH-1:0]   w_pattern;
    logic [MW-1:0]     w_popcnt;
    logic [MW-1:0]     w_thresh;
    logic              w_eval;
    logic              w_eval_fire;
    logic              w_push;

    // Two synchroniser flops followed by the edge-detect stage
    always_ff @(posedge pll_clk) begin
        if (!reset) begin
            r_c_s1 <= '0;
            r_c_s2 <= '0;
            r_c_s3 <= '0;
            r_t_s1 <= 1'b0;
            r_t_s2 <= 1'b0;
            r_t_s3 <= 1'b0;
        end else begin
            r_c_s1 <= c_input;
            r_c_s2 <= r_c_s1;
            r_c_s3 <= r_c_s2;
            r_t_s1 <= trig_in;
            r_t_s2 <= r_t_s1;
            r_t_s3 <= r_t_s2;
        end
    end

    assign w_hit      = r_c_s2 & ~r_c_s3 & chan_mask;
    assign w_trg_edge = r_t_s2 & ~r_t_s3;

    always_comb begin
        w_pattern = r_commit | w_hit;
        w_popcnt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_popcnt = w_popcnt + MW'(w_pattern[i]);
        end
    end

    assign w_thresh    = (min_mult == '0) ? MW'(1) : min_mult;
    assign w_eval      = (r_wcnt == c_wlast) || w_trg_edge;
    assign w_eval_fire = (w_popcnt >= w_thresh) || w_trg_edge;

    // Commit is always zero in IDLE, so w_pattern is the hit vector there
    always_comb begin
        w_push = 1'b0;
        case (r_state)
            S_IDLE:  w_push = w_trg_edge;
            S_OPEN:  w_push = w_eval && w_eval_fire;
            default: w_push = 1'b0;
        endcase
    end

    always_ff @(posedge pll_clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_commit <= '0;
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_hcnt   <= '0;
            r_trig   <= 1'b0;
            r_veto   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trg_edge) begin
                        r_state <= S_FIRE;
                        r_trig  <= 1'b1;
                        r_veto  <= 1'b1;
                        r_tcnt  <= c_tw'(1);
                    end else if (|w_hit) begin
                        r_state  <= S_OPEN;
                        r_commit <= w_hit;
                        r_wcnt   <= c_ww'(1);
                        r_veto   <= 1'b1;
                    end
                end
                S_OPEN: begin
                    if (w_eval) begin
                        r_commit <= '0;
                        r_wcnt   <= '0;
                        if (w_eval_fire) begin
                            r_state <= S_FIRE;
                            r_trig  <= 1'b1;
                            r_tcnt  <= c_tw'(1);
                        end else begin
                            r_state <= S_IDLE;
                            r_veto  <= 1'b0;
                        end
                    end else begin
                        r_commit <= w_pattern;
                        r_wcnt   <= r_wcnt + c_ww'(1);
                    end
                end
                S_FIRE: begin
                    if (r_tcnt == c_tlast) begin
                        r_trig <= 1'b0;
                        r_tcnt <= '0;
                        if (HOLDOFF == 0) begin
                            r_state <= S_IDLE;
                            r_veto  <= 1'b0;
                        end else begin
                            r_state <= S_HOLD;
                            r_hcnt  <= c_hw'(1);
                        end
                    end else begin
                        r_tcnt <= r_tcnt + c_tw'(1);
                    end
                end
                S_HOLD: begin
                    if (r_hcnt == c_hlast) begin
                        r_state <= S_IDLE;
                        r_hcnt  <= '0;
                        r_veto  <= 1'b0;
                    end else begin
                        r_hcnt <= r_hcnt + c_hw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign trig_out = r_trig;
    assign veto_out = r_veto;

    logic [c_ew-1:0] r_mem [FIFO_DEPTH];
    logic [c_pw:0]   r_wptr, r_rptr;
    logic [c_pw:0]   w_count;
    logic            w_empty, w_full, w_pop, w_wr;
    logic [c_ew-1:0] w_entry, w_head;

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge pll_clk) begin
        if (!reset) r_ts <= '0;
        else        r_ts <= r_ts + 32'd1;
    end

    assign w_entry = {r_ts, w_pattern};
    assign evt_ts  = w_head[c_ew-1:N_CH];
`else
    assign w_entry = w_pattern;
`endif

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_count == c_depth);
    assign w_pop   = !w_empty && evt_ready;
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge pll_clk) begin
        if (w_wr) r_mem[r_wptr[c_pw-1:0]] <= w_entry;
    end

    always_ff @(posedge pll_clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            drop_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_wr && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
        end
    end

    assign w_head      = w_empty ? '0 : r_mem[r_rptr[c_pw-1:0]];
    assign evt_pattern = w_head[N_CH-1:0];
    assign evt_valid   = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_trig_coinc_capture.sv
`default_nettype none
//==============================================================================
// Module   : tb_trig_coinc_capture
// Desc     : Directed self-checking bench; dut uses HOLDOFF=0, dut_h HOLDOFF=10.
// Revision : 1.0 - initial release
//==============================================================================
module tb_trig_coinc_capture;

    logic        pll_clk = 1'b0;
    logic        reset;
    logic [23:0] c_input, chan_mask;
    logic        trig_in;
    logic [4:0]  min_mult;
    logic        evt_ready;

    logic        trig_out, veto_out, evt_valid;
    logic [23:0] evt_pattern;
    logic [7:0]  drop_count;
    logic        h_trig_out, h_veto_out, h_evt_valid;
    logic [23:0] h_evt_pattern;
    logic [7:0]  h_drop_count;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] evt_ts, h_evt_ts;
`endif

    always #5 pll_clk = ~pll_clk;

    trig_coinc_capture #(.N_CH(24), .WINDOW(24), .TRIG_LEN(3), .HOLDOFF(0), .FIFO_DEPTH(4)) dut (
        .pll_clk(pll_clk), .reset(reset), .c_input(c_input), .chan_mask(chan_mask),
        .trig_in(trig_in), .min_mult(min_mult), .trig_out(trig_out), .veto_out(veto_out),
        .evt_pattern(evt_pattern), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .drop_count(drop_count)
`ifdef TRIG_TIMESTAMP_EN
        , .evt_ts(evt_ts)
`endif
    );

    trig_coinc_capture #(.N_CH(24), .WINDOW(24), .TRIG_LEN(3), .HOLDOFF(10), .FIFO_DEPTH(4)) dut_h (
        .pll_clk(pll_clk), .reset(reset), .c_input(c_input), .chan_mask(chan_mask),
        .trig_in(trig_in), .min_mult(min_mult), .trig_out(h_trig_out), .veto_out(h_veto_out),
        .evt_pattern(h_evt_pattern), .evt_valid(h_evt_valid), .evt_ready(evt_ready),
        .drop_count(h_drop_count)
`ifdef TRIG_TIMESTAMP_EN
        , .evt_ts(h_evt_ts)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int veto_first, veto_cnt, trig_first, trig_cnt, valid_cnt;
    int h_veto_cnt, h_trig_cnt;
    logic [23:0] pop_q[$];
    logic [23:0] h_pop_q[$];
    logic [23:0] got;

    task automatic clear_stats();
        veto_first = -1; veto_cnt = 0; trig_first = -1; trig_cnt = 0; valid_cnt = 0;
        h_veto_cnt = 0; h_trig_cnt = 0;
        pop_q.delete(); h_pop_q.delete();
    endtask

    // Pops are logged before the edge on which they happen; levels after it
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            if (evt_valid && evt_ready)   pop_q.push_back(evt_pattern);
            if (h_evt_valid && evt_ready) h_pop_q.push_back(h_evt_pattern);
            @(negedge pll_clk);
            cyc++;
            if (veto_out) begin
                if (veto_first < 0) veto_first = cyc;
                veto_cnt++;
            end
            if (trig_out) begin
                if (trig_first < 0) trig_first = cyc;
                trig_cnt++;
            end
            if (evt_valid)  valid_cnt++;
            if (h_veto_out) h_veto_cnt++;
            if (h_trig_out) h_trig_cnt++;
        end
    endtask

    task automatic pulse(input logic [23:0] ch);
        c_input = ch;
        observe(1);
        c_input = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        observe(2);
        reset = 1'b1;
        observe(1);
        clear_stats();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        observe(2);
        n_checks++; if (trig_out !== 1'b0) $display("FAIL reset_trig: got %b want 0", trig_out); else n_pass++;
        n_checks++; if (veto_out !== 1'b0) $display("FAIL reset_veto: got %b want 0", veto_out); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_pattern !== 24'h0) $display("FAIL reset_pattern: got %h want 000000", evt_pattern); else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else n_pass++;
        n_checks++; if (h_veto_out !== 1'b0) $display("FAIL reset_h_veto: got %b want 0", h_veto_out); else n_pass++;
        reset = 1'b1;
        observe(1);
        clear_stats();
    endtask

    task automatic test_coinc();
        min_mult = 5'd2; evt_ready = 1'b1;
        clear_stats();
        pulse(24'h000001);
        observe(9);
        pulse(24'h000020);
        observe(30);
        n_checks++; if (trig_first - veto_first !== 24) $display("FAIL coinc_latency: got %0d want 24", trig_first - veto_first); else n_pass++;
        n_checks++; if (trig_cnt !== 3) $display("FAIL coinc_trig_len: got %0d want 3", trig_cnt); else n_pass++;
        n_checks++; if (veto_cnt !== 27) $display("FAIL coinc_veto_len: got %0d want 27", veto_cnt); else n_pass++;
        n_checks++; if (valid_cnt !== 1) $display("FAIL coinc_valid_cycles: got %0d want 1", valid_cnt); else n_pass++;
        got = (pop_q.size() == 1) ? pop_q[0] : 24'hxxxxxx;
        n_checks++; if (got !== 24'h000021) $display("FAIL coinc_pattern: got %h want 000021", got); else n_pass++;
    endtask

    task automatic test_below();
        min_mult = 5'd3; evt_ready = 1'b1;
        clear_stats();
        pulse(24'h000001);
        observe(4);
        pulse(24'h000002);
        observe(35);
        n_checks++; if (veto_cnt !== 24) $display("FAIL below_veto_len: got %0d want 24", veto_cnt); else n_pass++;
        n_checks++; if (trig_cnt !== 0) $display("FAIL below_trig: got %0d want 0", trig_cnt); else n_pass++;
        n_checks++; if (valid_cnt !== 0) $display("FAIL below_fifo: got %0d want 0", valid_cnt); else n_pass++;
    endtask

    // A hit landing on the last window cycle counts; one cycle later it does not
    task automatic test_window_edge();
        min_mult = 5'd2; evt_ready = 1'b1;
        clear_stats();
        pulse(24'h000008);
        observe(23);
        pulse(24'h000010);
        observe(30);
        got = (pop_q.size() == 1) ? pop_q[0] : 24'hxxxxxx;
        n_checks++; if (got !== 24'h000018) $display("FAIL edge_last_cycle: got %h want 000018", got); else n_pass++;
        clear_stats();
        pulse(24'h000008);
        observe(24);
        pulse(24'h000010);
        observe(60);
        n_checks++; if (trig_cnt !== 0) $display("FAIL edge_past_window: got %0d want 0", trig_cnt); else n_pass++;
    endtask

    task automatic test_ext();
        min_mult = 5'd2; evt_ready = 1'b1;
        clear_stats();
        pulse(24'h000100);
        observe(6);
        trig_in = 1'b1;
        observe(1);
        trig_in = 1'b0;
        observe(20);
        n_checks++; if (trig_first - veto_first !== 7) $display("FAIL ext_open_latency: got %0d want 7", trig_first - veto_first); else n_pass++;
        n_checks++; if (trig_cnt !== 3) $display("FAIL ext_open_trig_len: got %0d want 3", trig_cnt); else n_pass++;
        n_checks++; if (veto_cnt !== 10) $display("FAIL ext_open_veto_len: got %0d want 10", veto_cnt); else n_pass++;
        got = (pop_q.size() == 1) ? pop_q[0] : 24'hxxxxxx;
        n_checks++; if (got !== 24'h000100) $display("FAIL ext_open_pattern: got %h want 000100", got); else n_pass++;
        clear_stats();
        trig_in = 1'b1;
        observe(1);
        trig_in = 1'b0;
        observe(10);
        n_checks++; if (trig_cnt !== 3) $display("FAIL ext_idle_trig_len: got %0d want 3", trig_cnt); else n_pass++;
        n_checks++; if (veto_cnt !== 3) $display("FAIL ext_idle_veto_len: got %0d want 3", veto_cnt); else n_pass++;
        got = (pop_q.size() == 1) ? pop_q[0] : 24'hxxxxxx;
        n_checks++; if (got !== 24'h000000) $display("FAIL ext_idle_pattern: got %h want 000000", got); else n_pass++;
    endtask

    task automatic test_mask_overflow();
        logic [23:0] exp_q[4];
        do_reset();
        chan_mask = 24'hFFFFFE; evt_ready = 1'b0; min_mult = 5'd2;
        pulse(24'h000001);
        observe(30);
        n_checks++; if (veto_cnt !== 0) $display("FAIL mask_ch0_window: got %0d veto cycles want 0", veto_cnt); else n_pass++;
        pulse(24'h000003);
        observe(30);
        n_checks++; if (trig_cnt !== 0) $display("FAIL mask_ch0_counted: got %0d trig cycles want 0", trig_cnt); else n_pass++;
        clear_stats();
        for (int i = 0; i < 6; i++) begin
            pulse(24'h000006 | (24'h000008 << i));
            observe(30);
        end
        n_checks++; if (trig_cnt !== 18) $display("FAIL ovf_trig_cycles: got %0d want 18", trig_cnt); else n_pass++;
        n_checks++; if (drop_count !== 8'd2) $display("FAIL ovf_drop: got %0d want 2", drop_count); else n_pass++;
        n_checks++; if (evt_pattern !== 24'h00000E) $display("FAIL ovf_head: got %h want 00000e", evt_pattern); else n_pass++;
        exp_q = '{24'h00000E, 24'h000016, 24'h000026, 24'h000046};
        evt_ready = 1'b1;
        observe(6);
        evt_ready = 1'b0;
        n_checks++; if (pop_q.size() !== 4) $display("FAIL ovf_pop_count: got %0d want 4", pop_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (pop_q.size() > i) ? pop_q[i] : 24'hxxxxxx;
            n_checks++; if (got !== exp_q[i]) $display("FAIL ovf_pop%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", evt_valid); else n_pass++;
        chan_mask = 24'hFFFFFF;
    endtask

    task automatic test_holdoff();
        do_reset();
        evt_ready = 1'b0; min_mult = 5'd2;
        pulse(24'h000006);
        observe(29);
        pulse(24'h000018);
        trig_in = 1'b1;
        observe(1);
        trig_in = 1'b0;
        observe(30);
        n_checks++; if (h_veto_cnt !== 37) $display("FAIL hold_veto_len: got %0d want 37", h_veto_cnt); else n_pass++;
        n_checks++; if (h_trig_cnt !== 3) $display("FAIL hold_trig_len: got %0d want 3", h_trig_cnt); else n_pass++;
        n_checks++; if (h_evt_pattern !== 24'h000006) $display("FAIL hold_head: got %h want 000006", h_evt_pattern); else n_pass++;
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            pulse(24'h000006 | (24'h000008 << i));
            observe(45);
        end
        pulse(24'h000060);
        observe(25);
        evt_ready = 1'b1;
        observe(1);
        evt_ready = 1'b0;
        observe(15);
        n_checks++; if (h_drop_count !== 8'd0) $display("FAIL pushpop_drop: got %0d want 0", h_drop_count); else n_pass++;
        evt_ready = 1'b1;
        observe(6);
        evt_ready = 1'b0;
        n_checks++; if (h_pop_q.size() !== 5) $display("FAIL pushpop_count: got %0d want 5", h_pop_q.size()); else n_pass++;
        got = (h_pop_q.size() > 1) ? h_pop_q[1] : 24'hxxxxxx;
        n_checks++; if (got !== 24'h00000E) $display("FAIL pushpop_second: got %h want 00000e", got); else n_pass++;
        got = (h_pop_q.size() > 4) ? h_pop_q[4] : 24'hxxxxxx;
        n_checks++; if (got !== 24'h000060) $display("FAIL pushpop_last: got %h want 000060", got); else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        evt_ready = 1'b0; min_mult = 5'd2;
        for (int i = 0; i < 3; i++) begin
            pulse(24'h000006);
            observe(30);
        end
        pulse(24'h000006);
        observe(27);
        n_checks++; if (trig_out !== 1'b1) $display("FAIL midrst_pre_trig: got %b want 1", trig_out); else n_pass++;
        reset = 1'b0;
        observe(1);
        n_checks++; if (trig_out !== 1'b0) $display("FAIL midrst_trig: got %b want 0", trig_out); else n_pass++;
        n_checks++; if (veto_out !== 1'b0) $display("FAIL midrst_veto: got %b want 0", veto_out); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_pattern !== 24'h0) $display("FAIL midrst_pattern: got %h want 000000", evt_pattern); else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL midrst_drop: got %0d want 0", drop_count); else n_pass++;
        reset = 1'b1;
        observe(3);
        clear_stats();
        evt_ready = 1'b1;
        pulse(24'h000006);
        observe(35);
        n_checks++; if (trig_first - veto_first !== 24) $display("FAIL midrst_idle_latency: got %0d want 24", trig_first - veto_first); else n_pass++;
        n_checks++; if (trig_cnt !== 3) $display("FAIL midrst_idle_trig_len: got %0d want 3", trig_cnt); else n_pass++;
    endtask

    initial begin
        reset = 1'b0; c_input = '0; chan_mask = 24'hFFFFFF; trig_in = 1'b0;
        min_mult = 5'd2; evt_ready = 1'b0;
        clear_stats();
        test_reset();
        test_coinc();
        test_below();
        test_window_edge();
        test_ext();
        test_mask_overflow();
        test_holdoff();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
